// File: rtl/div_alu.sv
// Multi-cycle 32-bit radix-2 restoring divider, signed or unsigned per request.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration and completes on the next cycle.
module div_alu (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic        start,
    input  logic [31:0] reg1,
    input  logic [31:0] reg2,
    input  logic        signed_op,
    output logic        busy,
    output logic        done,
    output logic [63:0] div_result
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [31:0] rem, quo, dsr, dvd_raw;
    logic        sgn_op, dvd_neg, dsr_neg, dsr_zero;

    logic        accept, fast_zero;
    logic [31:0] mag1, mag2;
    logic [32:0] shifted, diff;
    logic [31:0] rem_nx, quo_nx, q_fix, r_fix;
    logic [63:0] result_nx;

    assign accept = start && (state != RUN);
`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = accept && (reg2 == 32'd0);
`else
    assign fast_zero = 1'b0;
`endif

    assign mag1 = (signed_op && reg1[31]) ? (32'd0 - reg1) : reg1;
    assign mag2 = (signed_op && reg2[31]) ? (32'd0 - reg2) : reg2;

    // The dividend sits in the quotient register and shifts out MSB-first into the remainder.
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, dsr};
    assign rem_nx  = diff[32] ? shifted[31:0] : diff[31:0];
    assign quo_nx  = {quo[30:0], ~diff[32]};

    assign q_fix = (sgn_op && (dvd_neg ^ dsr_neg)) ? (32'd0 - quo_nx) : quo_nx;
    assign r_fix = (sgn_op && dvd_neg) ? (32'd0 - rem_nx) : rem_nx;
    // Divide-by-zero reports the raw dividend, not the sign-corrected magnitude path.
    assign result_nx = dsr_zero ? {dvd_raw, 32'hFFFF_FFFF} : {r_fix, q_fix};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, FIN: begin
                if (fast_zero)   state_nx = FIN;
                else if (start)  state_nx = RUN;
                else             state_nx = IDLE;
            end
            RUN:     if (cnt == 5'd31) state_nx = FIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) state <= IDLE;
        else           state <= state_nx;
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            dsr        <= '0;
            dvd_raw    <= '0;
            sgn_op     <= 1'b0;
            dvd_neg    <= 1'b0;
            dsr_neg    <= 1'b0;
            dsr_zero   <= 1'b0;
            div_result <= '0;
        end else if (accept) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= mag1;
            dsr      <= mag2;
            dvd_raw  <= reg1;
            sgn_op   <= signed_op;
            dvd_neg  <= reg1[31];
            dsr_neg  <= reg2[31];
            dsr_zero <= (reg2 == 32'd0);
            if (fast_zero) div_result <= {reg1, 32'hFFFF_FFFF};
        end else if (state == RUN) begin
            cnt <= cnt + 5'd1;
            rem <= rem_nx;
            quo <= quo_nx;
            if (cnt == 5'd31) div_result <= result_nx;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == FIN);

endmodule

// File: doc/div_alu.md
DIV_ALU -- requirements
Module: div_alu

Interface
REQ-001 SHALL have port cpu_clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port cpu_rstn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port start  input  1  division request, sampled on rising edge.
REQ-004 SHALL have port reg1  input  32  dividend, sampled with start.
REQ-005 SHALL have port reg2  input  32  divisor, sampled with start.
REQ-006 SHALL have port signed_op  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
REQ-007 SHALL have port busy  output  1  high while an accepted division is iterating.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port div_result  output  64  {remainder[63:32], quotient[31:0]}.

Function
REQ-010 SHALL implement states IDLE, RUN and FIN, held in a registered state machine.
REQ-011 SHALL accept start only in IDLE or FIN: capture operands, signed_op, and the dividend and divisor sign bits; load the magnitudes (|x| when signed_op=1, else raw); clear the 5-bit iteration counter; enter RUN.
REQ-012 SHALL ignore start while in RUN, with no effect on operands, counter or result.
REQ-013 SHALL perform one radix-2 restoring step per RUN cycle: shift {partial remainder, quotient} left 1, and on a non-negative trial subtract set the quotient LSB and keep the difference.
REQ-014 SHALL leave RUN after exactly 32 iterations (counter 31), registering the sign-corrected result into div_result and entering FIN.
REQ-015 SHALL assert done only in FIN, for exactly one cycle, i.e. on the 33rd cycle after the start-sampling edge; busy SHALL equal (state==RUN).
REQ-016 SHALL return FIN to IDLE when start=0, and to RUN (back-to-back) when start=1.
REQ-017 SHALL negate the quotient when signed_op=1 and the dividend and divisor signs differ, truncating toward zero.
REQ-018 SHALL negate the remainder when signed_op=1 and the dividend is negative, so the remainder sign follows the dividend.
REQ-019 SHALL produce quotient 0x80000000 and remainder 0 for signed 0x80000000 / 0xFFFFFFFF (32-bit wrap, no trap).
REQ-020 SHALL produce quotient 0xFFFFFFFF and remainder = captured reg1 for any divisor of 0, regardless of signed_op.
REQ-021 SHALL hold div_result stable from FIN until the next FIN update; RUN SHALL never modify div_result.

Reset
REQ-022 SHALL, on cpu_rstn low, immediately force state IDLE, busy 0, done 0, div_result 0 and counter 0.
REQ-023 SHALL abort an in-flight division on reset, with no done pulse and no result update after release.
REQ-024 SHALL accept start on the first rising edge after cpu_rstn deasserts.

Configuration
REQ-025 SHALL support macro DIV_ZERO_FAST_EN; when defined, a start with reg2=0 SHALL go directly to FIN, writing the REQ-020 result, with done high on the cycle after the start edge and busy never asserted.
REQ-026 SHALL, without DIV_ZERO_FAST_EN, run divide-by-zero through the full 32 RUN cycles, producing the REQ-020 result with standard REQ-015 timing.

Verification
REQ-027 SHALL be tested with unsigned 100/7: done on cycle 33, div_result = {0x00000002, 0x0000000E}.
REQ-028 SHALL be tested with signed -7/2 (0xFFFFFFF9/0x00000002): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; the same operands unsigned give quotient 0x7FFFFFFC, remainder 0x00000001.
REQ-029 SHALL be tested with signed 0x80000000/0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-030 SHALL be tested with 5/0: quotient 0xFFFFFFFF, remainder 5; done on cycle 1 with DIV_ZERO_FAST_EN, cycle 33 without.
REQ-031 SHALL be tested with start pulsed at cycle 10 during a busy 100/7, then start in FIN with 9/3: the first result is unaffected, and the second completes 33 cycles later with {0, 3}.
REQ-032 SHALL be tested with cpu_rstn low at cycle 15 of a division: done stays 0, div_result = 0, busy = 0 until the next start.
